// File: rtl/ctrl_hazard_pipe_if.sv
// Pipeline control/hazard bus: D-stage request fields in, per-stage control,
// stall and forwarding selects out.
interface ctrl_hazard_pipe_if #(
  parameter int unsigned CTRL_W = 24
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned FSEL_W = 2;

  // D-stage instruction
  logic [CTRL_W-1:0] ctrl_d;
  logic [REG_W-1:0]  rs_d;
  logic [REG_W-1:0]  rt_d;
  logic              use_rs_d;
  logic              use_rt_d;
  logic [TNEW_W-1:0] tuse_d;
  logic [REG_W-1:0]  a3_d;
  logic              regwrite_d;
  logic [TNEW_W-1:0] tnew_d;
  logic              flush_e;

  // hazard outputs
  logic              stall;
  logic [FSEL_W-1:0] fwd_rs_d;
  logic [FSEL_W-1:0] fwd_rt_d;
  logic [FSEL_W-1:0] fwd_rs_e;
  logic [FSEL_W-1:0] fwd_rt_e;

  // per-stage control
  logic [CTRL_W-1:0] ctrl_e;
  logic [CTRL_W-1:0] ctrl_m;
  logic [CTRL_W-1:0] ctrl_w;
  logic [REG_W-1:0]  a3_e;
  logic [REG_W-1:0]  a3_m;
  logic [REG_W-1:0]  a3_w;
  logic              regwrite_e;
  logic              regwrite_m;
  logic              regwrite_w;
  logic [REG_W-1:0]  rs_e;
  logic [REG_W-1:0]  rt_e;

  modport master (
    output ctrl_d, rs_d, rt_d, use_rs_d, use_rt_d, tuse_d, a3_d, regwrite_d,
           tnew_d, flush_e,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
           ctrl_e, ctrl_m, ctrl_w, a3_e, a3_m, a3_w,
           regwrite_e, regwrite_m, regwrite_w, rs_e, rt_e
  );

  modport slave (
    input  ctrl_d, rs_d, rt_d, use_rs_d, use_rt_d, tuse_d, a3_d, regwrite_d,
           tnew_d, flush_e,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
           ctrl_e, ctrl_m, ctrl_w, a3_e, a3_m, a3_w,
           regwrite_e, regwrite_m, regwrite_w, rs_e, rt_e
  );
endinterface

// File: rtl/ctrl_hazard_pipe.sv
// E/M/W control pipeline with Tnew/Tuse stall detection and forwarding selects.
module ctrl_hazard_pipe #(
  parameter int unsigned CTRL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  ctrl_hazard_pipe_if.slave  bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned FSEL_W = 2;

  localparam logic [FSEL_W-1:0] SEL_RF = 2'd0;
  localparam logic [FSEL_W-1:0] SEL_M  = 2'd1;
  localparam logic [FSEL_W-1:0] SEL_W  = 2'd2;
  localparam logic [FSEL_W-1:0] SEL_E  = 2'd3;

  logic [TNEW_W-1:0] tnew_e;
  logic [TNEW_W-1:0] tnew_m;
  logic              issue_c;

  // producer writes r, and r is not the hardwired zero register
  function automatic logic hit(input logic rw, input logic [REG_W-1:0] a3,
                               input logic [REG_W-1:0] r);
    return rw && (a3 == r) && (r != '0);
  endfunction

  logic hit_e_rs, hit_m_rs, hit_w_rs;
  logic hit_e_rt, hit_m_rt, hit_w_rt;
  logic hit_m_rse, hit_w_rse, hit_m_rte, hit_w_rte;

  assign hit_e_rs  = hit(bus.regwrite_e, bus.a3_e, bus.rs_d);
  assign hit_m_rs  = hit(bus.regwrite_m, bus.a3_m, bus.rs_d);
  assign hit_w_rs  = hit(bus.regwrite_w, bus.a3_w, bus.rs_d);
  assign hit_e_rt  = hit(bus.regwrite_e, bus.a3_e, bus.rt_d);
  assign hit_m_rt  = hit(bus.regwrite_m, bus.a3_m, bus.rt_d);
  assign hit_w_rt  = hit(bus.regwrite_w, bus.a3_w, bus.rt_d);
  assign hit_m_rse = hit(bus.regwrite_m, bus.a3_m, bus.rs_e);
  assign hit_w_rse = hit(bus.regwrite_w, bus.a3_w, bus.rs_e);
  assign hit_m_rte = hit(bus.regwrite_m, bus.a3_m, bus.rt_e);
  assign hit_w_rte = hit(bus.regwrite_w, bus.a3_w, bus.rt_e);

  // stall when an in-flight producer of a used source is not ready by Tuse
  always_comb begin
    logic stall_rs;
    logic stall_rt;
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (bus.use_rs_d) begin
      stall_rs = (hit_e_rs && (tnew_e > bus.tuse_d)) ||
                 (hit_m_rs && (tnew_m > bus.tuse_d));
    end
    if (bus.use_rt_d) begin
      stall_rt = (hit_e_rt && (tnew_e > bus.tuse_d)) ||
                 (hit_m_rt && (tnew_m > bus.tuse_d));
    end
    bus.stall = stall_rs | stall_rt;
  end

  // D-stage selects: youngest ready producer wins; not-ready ones fall through
  always_comb begin
    bus.fwd_rs_d = SEL_RF;
    bus.fwd_rt_d = SEL_RF;
    if (hit_e_rs && (tnew_e == '0))      bus.fwd_rs_d = SEL_E;
    else if (hit_m_rs && (tnew_m == '0)) bus.fwd_rs_d = SEL_M;
    else if (hit_w_rs)                   bus.fwd_rs_d = SEL_W;
    if (hit_e_rt && (tnew_e == '0))      bus.fwd_rt_d = SEL_E;
    else if (hit_m_rt && (tnew_m == '0)) bus.fwd_rt_d = SEL_M;
    else if (hit_w_rt)                   bus.fwd_rt_d = SEL_W;
  end

  // E-stage selects from M (ready only) and W
  always_comb begin
    bus.fwd_rs_e = SEL_RF;
    bus.fwd_rt_e = SEL_RF;
    if (hit_m_rse && (tnew_m == '0)) bus.fwd_rs_e = SEL_M;
    else if (hit_w_rse)              bus.fwd_rs_e = SEL_W;
    if (hit_m_rte && (tnew_m == '0)) bus.fwd_rt_e = SEL_M;
    else if (hit_w_rte)              bus.fwd_rt_e = SEL_W;
  end

  // a stalled or annulled D instruction becomes a bubble in E
  assign issue_c = !bus.stall && !bus.flush_e;

  // E stage: take D on issue, otherwise a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ctrl_e     <= '0;
      bus.a3_e       <= '0;
      bus.regwrite_e <= 1'b0;
      bus.rs_e       <= '0;
      bus.rt_e       <= '0;
      tnew_e         <= '0;
    end else if (issue_c) begin
      bus.ctrl_e     <= bus.ctrl_d;
      bus.a3_e       <= bus.a3_d;
      bus.regwrite_e <= bus.regwrite_d;
      bus.rs_e       <= bus.rs_d;
      bus.rt_e       <= bus.rt_d;
      tnew_e         <= bus.tnew_d;
    end else begin
      bus.ctrl_e     <= CTRL_W'(0);
      bus.a3_e       <= '0;
      bus.regwrite_e <= 1'b0;
      bus.rs_e       <= '0;
      bus.rt_e       <= '0;
      tnew_e         <= '0;
    end
  end

  // M stage: always advances from E, Tnew counts down and saturates at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ctrl_m     <= '0;
      bus.a3_m       <= '0;
      bus.regwrite_m <= 1'b0;
      tnew_m         <= '0;
    end else begin
      bus.ctrl_m     <= bus.ctrl_e;
      bus.a3_m       <= bus.a3_e;
      bus.regwrite_m <= bus.regwrite_e;
      tnew_m         <= (tnew_e == '0) ? '0 : tnew_e - TNEW_W'(1);
    end
  end

  // W stage: always advances from M; results are ready here by construction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ctrl_w     <= '0;
      bus.a3_w       <= '0;
      bus.regwrite_w <= 1'b0;
    end else begin
      bus.ctrl_w     <= bus.ctrl_m;
      bus.a3_w       <= bus.a3_m;
      bus.regwrite_w <= bus.regwrite_m;
    end
  end
endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Self-checking bench for ctrl_hazard_pipe: directed hazard scenarios plus
// random traffic against an instruction-level pipeline model.
module tb_ctrl_hazard_pipe;
  localparam int unsigned CTRL_W = 24;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_hazard_pipe_if #(.CTRL_W(CTRL_W)) bus ();

  ctrl_hazard_pipe #(.CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // one in-flight instruction as the model sees it
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    int                a3;
    bit                rw;
    int                rs;
    int                rt;
    int                tnew;   // cycles until result exists, counted from E
  } instr_t;

  instr_t pipe [3];  // 0 = E, 1 = M, 2 = W
  instr_t cur_d;
  bit     cur_urs, cur_urt, cur_flush;
  int     cur_tuse;
  bit     exp_stall;
  int     n_vec;
  int     n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.ctrl = '0; b.a3 = 0; b.rw = 1'b0; b.rs = 0; b.rt = 0; b.tnew = 0;
    return b;
  endfunction

  function automatic bit writes(instr_t s, int r);
    return s.rw && (s.a3 == r) && (r != 0);
  endfunction

  // some in-flight writer of r will not have its result by Tuse
  function automatic bit blocked(int r, int tuse);
    for (int i = 0; i < 3; i++)
      if (writes(pipe[i], r) && pipe[i].tnew > tuse) return 1'b1;
    return 1'b0;
  endfunction

  // youngest in-flight writer of r whose result already exists
  function automatic int d_sel(int r);
    int code [3];
    code = '{3, 1, 2};
    for (int i = 0; i < 3; i++)
      if (writes(pipe[i], r) && pipe[i].tnew == 0) return code[i];
    return 0;
  endfunction

  function automatic int e_sel(int r);
    int code [3];
    code = '{0, 1, 2};
    for (int i = 1; i < 3; i++)
      if (writes(pipe[i], r) && pipe[i].tnew == 0) return code[i];
    return 0;
  endfunction

  function automatic bit predict_stall();
    return (cur_urs && blocked(cur_d.rs, cur_tuse)) ||
           (cur_urt && blocked(cur_d.rt, cur_tuse));
  endfunction

  task automatic check_all();
    check("stall",      32'(bus.stall),      32'(exp_stall));
    check("fwd_rs_d",   32'(bus.fwd_rs_d),   32'(d_sel(cur_d.rs)));
    check("fwd_rt_d",   32'(bus.fwd_rt_d),   32'(d_sel(cur_d.rt)));
    check("fwd_rs_e",   32'(bus.fwd_rs_e),   32'(e_sel(pipe[0].rs)));
    check("fwd_rt_e",   32'(bus.fwd_rt_e),   32'(e_sel(pipe[0].rt)));
    check("ctrl_e",     32'(bus.ctrl_e),     32'(pipe[0].ctrl));
    check("ctrl_m",     32'(bus.ctrl_m),     32'(pipe[1].ctrl));
    check("ctrl_w",     32'(bus.ctrl_w),     32'(pipe[2].ctrl));
    check("a3_e",       32'(bus.a3_e),       32'(pipe[0].a3));
    check("a3_m",       32'(bus.a3_m),       32'(pipe[1].a3));
    check("a3_w",       32'(bus.a3_w),       32'(pipe[2].a3));
    check("regwrite_e", 32'(bus.regwrite_e), 32'(pipe[0].rw));
    check("regwrite_m", 32'(bus.regwrite_m), 32'(pipe[1].rw));
    check("regwrite_w", 32'(bus.regwrite_w), 32'(pipe[2].rw));
    check("rs_e",       32'(bus.rs_e),       32'(pipe[0].rs));
    check("rt_e",       32'(bus.rt_e),       32'(pipe[0].rt));
  endtask

  // present a D instruction, let it settle, compare everything
  task automatic apply(input logic [CTRL_W-1:0] ctrl, input int a3, input bit rw,
                       input int tnew, input int rs, input bit urs, input int rt,
                       input bit urt, input int tuse, input bit flush);
    cur_d.ctrl = ctrl; cur_d.a3 = a3; cur_d.rw = rw; cur_d.tnew = tnew;
    cur_d.rs = rs; cur_d.rt = rt;
    cur_urs = urs; cur_urt = urt; cur_tuse = tuse; cur_flush = flush;
    bus.ctrl_d     = ctrl;
    bus.a3_d       = 5'(a3);
    bus.regwrite_d = rw;
    bus.tnew_d     = 2'(tnew);
    bus.rs_d       = 5'(rs);
    bus.use_rs_d   = urs;
    bus.rt_d       = 5'(rt);
    bus.use_rt_d   = urt;
    bus.tuse_d     = 2'(tuse);
    bus.flush_e    = flush;
    #1;
    exp_stall = predict_stall();
    check_all();
  endtask

  task automatic nop();
    apply('0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // advance model alongside the DUT's clock edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = bubble();
    end else begin
      pipe[2] = pipe[1];
      pipe[2].tnew = 0;
      pipe[1] = pipe[0];
      pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
      if (!exp_stall && !cur_flush) pipe[0] = cur_d;
      else pipe[0] = bubble();
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    rst_n = 1'b0;
    nop();
    tick();
    nop();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // load-use: lw $8 then add reading $8 at Tuse 1
    apply(24'h0a0001, 8, 1'b1, 2, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    apply(24'h0b0002, 10, 1'b1, 1, 8, 1'b1, 9, 1'b1, 1, 1'b0);
    check("t1_stall", 32'(bus.stall), 32'd1);
    tick();
    apply(24'h0b0002, 10, 1'b1, 1, 8, 1'b1, 9, 1'b1, 1, 1'b0);
    check("t1_stall_clear", 32'(bus.stall), 32'd0);
    check("t1_bubble_e", 32'(bus.regwrite_e), 32'd0);
    tick();
    nop();
    check("t1_fwd_rs_e", 32'(bus.fwd_rs_e), 32'd2);
    tick();
    drain();

    // branch right after an ALU producer
    apply(24'h0c0003, 5, 1'b1, 1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    apply(24'h0d0004, 0, 1'b0, 0, 5, 1'b1, 0, 1'b0, 0, 1'b0);
    check("t2_stall", 32'(bus.stall), 32'd1);
    tick();
    apply(24'h0d0004, 0, 1'b0, 0, 5, 1'b1, 0, 1'b0, 0, 1'b0);
    check("t2_stall_clear", 32'(bus.stall), 32'd0);
    check("t2_fwd_rs_d", 32'(bus.fwd_rs_d), 32'd1);
    tick();
    drain();

    // jal then jr $31
    apply(24'h0e0005, 31, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    apply(24'h0f0006, 0, 1'b0, 0, 31, 1'b1, 0, 1'b0, 0, 1'b0);
    check("t3_stall", 32'(bus.stall), 32'd0);
    check("t3_fwd_rs_d", 32'(bus.fwd_rs_d), 32'd3);
    tick();
    drain();

    // writer of $0 never stalls nor forwards
    apply(24'h100007, 0, 1'b1, 2, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    apply(24'h110008, 0, 1'b0, 0, 0, 1'b1, 0, 1'b1, 0, 1'b0);
    check("t4_zero_stall", 32'(bus.stall), 32'd0);
    check("t4_zero_fwd_rs", 32'(bus.fwd_rs_d), 32'd0);
    check("t4_zero_fwd_rt", 32'(bus.fwd_rt_d), 32'd0);
    tick();
    drain();

    // $9 written from E, M and W at once: E wins
    for (int i = 0; i < 3; i++) begin
      apply(24'h120000 + 24'(i), 9, 1'b1, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      tick();
    end
    apply(24'h130009, 0, 1'b0, 0, 9, 1'b1, 0, 1'b0, 0, 1'b0);
    check("t4_prio_fwd", 32'(bus.fwd_rs_d), 32'd3);
    check("t4_prio_stall", 32'(bus.stall), 32'd0);
    tick();
    drain();

    // flush_e annuls D while the E instruction moves on
    apply(24'h123456, 6, 1'b1, 1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    apply(24'habcdef, 4, 1'b1, 1, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    nop();
    check("t5_regwrite_e", 32'(bus.regwrite_e), 32'd0);
    check("t5_a3_e", 32'(bus.a3_e), 32'd0);
    check("t5_ctrl_e", 32'(bus.ctrl_e), 32'd0);
    check("t5_ctrl_m", 32'(bus.ctrl_m), 32'h123456);
    check("t5_a3_m", 32'(bus.a3_m), 32'd6);
    tick();
    drain();

    // reset asserted during a stall clears everything at once
    apply(24'h140010, 8, 1'b1, 2, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    apply(24'h150011, 11, 1'b1, 1, 8, 1'b1, 0, 1'b0, 0, 1'b0);
    check("t6_stall_before", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_stall", 32'(bus.stall), 32'd0);
    check("t6_rst_regwrite_e", 32'(bus.regwrite_e), 32'd0);
    check("t6_rst_a3_e", 32'(bus.a3_e), 32'd0);
    check("t6_rst_ctrl_e", 32'(bus.ctrl_e), 32'd0);
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    exp_stall = predict_stall();
    check_all();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    apply(24'h777777, 12, 1'b1, 1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    nop();
    check("t6_issue_ctrl_e", 32'(bus.ctrl_e), 32'h777777);
    check("t6_issue_a3_e", 32'(bus.a3_e), 32'd12);
    tick();
    drain();

    // random traffic on a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      apply(24'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom),
            int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
